// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan decoder: active-low segment patterns,
// blank anode code, FSM state type and the anode select decode helper.
package seg7_pkg;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b0000011;
  localparam logic [6:0] SEG_C = 7'b1000110;
  localparam logic [6:0] SEG_D = 7'b0100001;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_F = 7'b0001110;

  localparam logic [3:0] AN_NONE = 4'b1111;

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

  // Returns {valid, index}: valid only when exactly one anode line is low.
  function automatic logic [2:0] an_decode(input logic [3:0] an);
    case (an)
      4'b1110: an_decode = 3'b100;
      4'b1101: an_decode = 3'b101;
      4'b1011: an_decode = 3'b110;
      4'b0111: an_decode = 3'b111;
      default: an_decode = 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational inverse decode of an active-low gfedcba pattern to a hex nibble;
// hit is low for any pattern outside the 16-entry table.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic       hit,
  output logic [3:0] nibble
);

  always_comb begin
    // NOTE: both outputs are defaulted before the case so no latch can be inferred.
    hit    = 1'b1;
    nibble = 4'h0;
    case (seg)
      SEG_0:   nibble = 4'h0;
      SEG_1:   nibble = 4'h1;
      SEG_2:   nibble = 4'h2;
      SEG_3:   nibble = 4'h3;
      SEG_4:   nibble = 4'h4;
      SEG_5:   nibble = 4'h5;
      SEG_6:   nibble = 4'h6;
      SEG_7:   nibble = 4'h7;
      SEG_8:   nibble = 4'h8;
      SEG_9:   nibble = 4'h9;
      SEG_A:   nibble = 4'hA;
      SEG_B:   nibble = 4'hB;
      SEG_C:   nibble = 4'hC;
      SEG_D:   nibble = 4'hD;
      SEG_E:   nibble = 4'hE;
      SEG_F:   nibble = 4'hF;
      default: hit    = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Receive-side monitor for a scanned 4-digit 7-segment display; rebuilds the 16-bit value.
// Options: SEG7DEC_SYNC_EN (2-flop input synchronizer), SEG7DEC_DP_EN (decimal point capture).
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int SETTLE_CYCLES = 16,
  parameter int CNT_W         = 8
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [3:0]  an,
  input  logic [6:0]  a_to_g,
  input  logic        dp,
  output logic [15:0] x,
  output logic        x_valid,
  output logic [3:0]  seen,
  output logic        digit_err,
  output logic [3:0]  dp_out
);

  logic [3:0] in_an;
  logic [6:0] in_seg;
  logic       in_dp;

`ifdef SEG7DEC_SYNC_EN
  logic [11:0] sync1, sync2;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      // NOTE: registered state is always written with <= so every flop sees pre-edge values.
      sync1 <= {dp, an, a_to_g};
      sync2 <= sync1;
    end
  end

  assign {in_dp, in_an, in_seg} = sync2;
`else
  assign {in_dp, in_an, in_seg} = {dp, an, a_to_g};
`endif

  logic [3:0] s_an, p_an;
  logic [6:0] s_seg, p_seg;
  logic       s_dp;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      s_an  <= AN_NONE;
      p_an  <= AN_NONE;
      s_seg <= '1;
      p_seg <= '1;
      s_dp  <= 1'b1;
    end else begin
      s_an  <= in_an;
      p_an  <= s_an;
      s_seg <= in_seg;
      p_seg <= s_seg;
      s_dp  <= in_dp;
    end
  end

  logic       an_ok;
  logic [1:0] an_idx;
  logic       same;
  logic       dec_hit;
  logic [3:0] dec_nib;

  assign {an_ok, an_idx} = an_decode(s_an);
  assign same            = (s_an == p_an) && (s_seg == p_seg);

  seg7_pattern_decode u_dec (
    .seg    (s_seg),
    .hit    (dec_hit),
    .nibble (dec_nib)
  );

  state_t             state, state_n;
  logic   [CNT_W-1:0] cnt, cnt_n;
  logic               accept;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    accept  = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (an_ok) state_n = SETTLE;
      end
      SETTLE: begin
        if (!same) begin
          cnt_n   = '0;
          state_n = an_ok ? SETTLE : IDLE;
        end else if (cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
          accept  = 1'b1;
          state_n = HOLD;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      HOLD: begin
        // Counter stays saturated until the digit or pattern changes.
        if (!same) begin
          cnt_n   = '0;
          state_n = an_ok ? SETTLE : IDLE;
        end
      end
      default: begin
        cnt_n   = '0;
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  logic [15:0] shadow, merged;
  logic [3:0]  seen_acc;

  always_comb begin
    merged                     = shadow;
    merged[{an_idx, 2'b00} +: 4] = dec_nib;
  end

  assign seen_acc = seen | (4'b0001 << an_idx);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      // NOTE: shadow is a small flop array, not RAM, so it takes the async clear like any register.
      shadow    <= '0;
      x         <= '0;
      x_valid   <= 1'b0;
      seen      <= '0;
      digit_err <= 1'b0;
    end else begin
      x_valid   <= 1'b0;
      digit_err <= 1'b0;
      if (accept) begin
        if (dec_hit) begin
          shadow <= merged;
          if (seen_acc == 4'hF) begin
            x       <= merged;
            x_valid <= 1'b1;
            seen    <= '0;
          end else begin
            seen <= seen_acc;
          end
        end else begin
          digit_err <= 1'b1;
        end
      end
    end
  end

`ifdef SEG7DEC_DP_EN
  logic [3:0] dp_shadow, dp_merged;

  always_comb begin
    dp_merged         = dp_shadow;
    dp_merged[an_idx] = ~s_dp;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      dp_shadow <= '0;
      dp_out    <= '0;
    end else if (accept && dec_hit) begin
      dp_shadow <= dp_merged;
      if (seen_acc == 4'hF) dp_out <= dp_merged;
    end
  end
`else
  logic unused_dp;
  assign unused_dp = s_dp;
  assign dp_out    = '0;
`endif

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder: expected frames queued as scans are driven,
// compared when x_valid pulses; side checks on seen, digit_err and settle timing.
module tb_seg7_scan_decoder;
  import seg7_pkg::*;

  logic        clk = 1'b0;
  logic        clr;
  logic [3:0]  an;
  logic [6:0]  a_to_g;
  logic        dp;
  logic [15:0] x;
  logic        x_valid;
  logic [3:0]  seen;
  logic        digit_err;
  logic [3:0]  dp_out;

  seg7_scan_decoder dut (
    .clk       (clk),
    .clr       (clr),
    .an        (an),
    .a_to_g    (a_to_g),
    .dp        (dp),
    .x         (x),
    .x_valid   (x_valid),
    .seen      (seen),
    .digit_err (digit_err),
    .dp_out    (dp_out)
  );

  always #5 clk = ~clk;

  logic [6:0] seg_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  int          n_vec  = 0;
  int          n_miss = 0;
  int          n_xv   = 0;
  int          n_errp = 0;
  logic [15:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: each x_valid pulse consumes one queued frame.
  always @(negedge clk) begin
    if (x_valid === 1'b1) begin
      n_xv++;
      if (exp_q.size() == 0) check("x_valid_unexpected", 32'd1, 32'd0);
      else                   check("frame_x", {16'h0, x}, {16'h0, exp_q.pop_front()});
    end
    if (digit_err === 1'b1) n_errp++;
  end

  task automatic show_digit(input int idx, input logic [3:0] nib, input int dwell);
    an     = ~(4'b0001 << idx);
    a_to_g = seg_tab[nib];
    repeat (dwell) @(negedge clk);
  endtask

  task automatic blank(input int n);
    an = 4'b1111;
    repeat (n) @(negedge clk);
  endtask

  task automatic scan(input logic [15:0] v, input int dwell);
    for (int i = 0; i < 4; i++) begin
      show_digit(i, v[4*i +: 4], dwell);
      blank(2);
    end
  endtask

  int xv0, er0, waited;

  initial begin
    clr    = 1'b1;
    an     = 4'b1111;
    a_to_g = 7'h7F;
    dp     = 1'b1;
    repeat (3) @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    check("rst_x", {16'h0, x}, 32'h0);
    check("rst_x_valid", {31'h0, x_valid}, 32'h0);
    check("rst_seen", {28'h0, seen}, 32'h0);
    check("rst_digit_err", {31'h0, digit_err}, 32'h0);
    check("rst_dp_out", {28'h0, dp_out}, 32'h0);

    // Short dwell: never settles.
    xv0 = n_xv;
    scan(16'h1234, 8);
    check("short_seen", {28'h0, seen}, 32'h0);
    check("short_x", {16'h0, x}, 32'h0);
    check("short_xv_count", n_xv - xv0, 32'd0);

    // Full scans of 1234, twice.
    xv0 = n_xv;
    show_digit(0, 4'h4, 32); blank(2);
    show_digit(1, 4'h3, 32); blank(2);
    check("mid_seen", {28'h0, seen}, 32'h3);
    exp_q.push_back(16'h1234);
    show_digit(2, 4'h2, 32); blank(2);
    show_digit(3, 4'h1, 32); blank(4);
    check("scan1_x", {16'h0, x}, 32'h1234);
    check("scan1_seen", {28'h0, seen}, 32'h0);
    check("scan1_xv_count", n_xv - xv0, 32'd1);
    exp_q.push_back(16'h1234);
    scan(16'h1234, 32);
    check("scan2_xv_count", n_xv - xv0, 32'd2);
    check("scan2_seen", {28'h0, seen}, 32'h0);

    // Blank pattern on digit 2 is a decode miss.
    xv0 = n_xv;
    er0 = n_errp;
    show_digit(0, 4'h8, 32); blank(2);
    show_digit(1, 4'h7, 32); blank(2);
    an = 4'b1011; a_to_g = 7'b1111111;
    repeat (32) @(negedge clk);
    blank(2);
    check("miss_err_count", n_errp - er0, 32'd1);
    check("miss_seen", {28'h0, seen}, 32'h3);
    show_digit(3, 4'h5, 32); blank(2);
    check("miss_seen_d3", {28'h0, seen}, 32'hB);
    check("miss_no_xv", n_xv - xv0, 32'd0);
    exp_q.push_back(16'h5678);
    show_digit(2, 4'h6, 32); blank(4);
    check("miss_recover_xv", n_xv - xv0, 32'd1);

    // Multi-select and blank gaps between digits.
    er0 = n_errp;
    exp_q.push_back(16'hCAFE);
    for (int i = 0; i < 4; i++) begin
      show_digit(i, 16'hCAFE >> (4*i), 32);
      an = (i % 2 == 0) ? 4'b0011 : 4'b1111;
      repeat (20) @(negedge clk);
      if (i == 0) begin
        check("gap_fsm_idle", {30'h0, dut.state}, {30'h0, IDLE});
        check("gap_cnt_zero", {24'h0, dut.cnt}, 32'h0);
        check("gap_seen", {28'h0, seen}, 32'h1);
      end
    end
    blank(2);
    check("gap_no_err", n_errp - er0, 32'd0);
    check("gap_x", {16'h0, x}, 32'hCAFE);

    // One-cycle glitch on the last digit restarts settling.
    er0 = n_errp;
    xv0 = n_xv;
    show_digit(0, 4'hF, 32); blank(2);
    show_digit(1, 4'hE, 32); blank(2);
    show_digit(2, 4'hE, 32); blank(2);
    exp_q.push_back(16'hBEEF);
    show_digit(3, 4'hB, 10);
    a_to_g = 7'h7F;
    @(negedge clk);
    a_to_g = seg_tab[4'hB];
    waited = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (x_valid === 1'b1) begin
        waited = c;
        break;
      end
    end
    check("glitch_seen_before", {31'h0, (waited >= 14)}, 32'd1);
    check("glitch_accept_window", {31'h0, (waited >= 14 && waited <= 22)}, 32'd1);
    blank(4);
    check("glitch_x", {16'h0, x}, 32'hBEEF);
    check("glitch_no_err", n_errp - er0, 32'd0);

    // Reset mid-frame discards partial capture.
    show_digit(0, 4'h3, 32); blank(2);
    show_digit(1, 4'hC, 32); blank(2);
    show_digit(2, 4'h5, 32); blank(2);
    check("pre_clr_seen", {28'h0, seen}, 32'h7);
    clr = 1'b1;
    repeat (2) @(negedge clk);
    check("clr_seen", {28'h0, seen}, 32'h0);
    check("clr_x", {16'h0, x}, 32'h0);
    clr = 1'b0;
    @(negedge clk);
    exp_q.push_back(16'hA5C3);
    show_digit(3, 4'hA, 32); blank(2);
    check("post_clr_seen", {28'h0, seen}, 32'h8);
    check("post_clr_x", {16'h0, x}, 32'h0);
    scan(16'hA5C3, 32);
    check("post_clr_x_final", {16'h0, x}, 32'hA5C3);

    check("queue_drained", exp_q.size(), 32'd0);
    check("dp_out_tied", {28'h0, dp_out}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
